// File: rtl/sys_defs.sv
// System-wide cache and memory bus definitions
// shared by the victim cache and its writeback path.
package sys_defs;

  localparam int NUM_SET_BITS = 5;
  localparam int NUM_TAG_BITS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef struct packed {
    logic                    valid;
    logic [NUM_TAG_BITS-1:0] tag;
    logic [63:0]             data;
  } CACHE_LINE_T;

endpackage

// File: rtl/vic_wb_buffer_pkg.sv
// Writeback buffer entry, FSM state and
// address formation helper.
package vic_wb_buffer_pkg;

  import sys_defs::*;

  typedef struct packed {
    logic                    valid;
    logic [NUM_TAG_BITS-1:0] tag;
    logic [NUM_SET_BITS-1:0] set_index;
    logic [63:0]             data;
  } WB_ENTRY_T;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } WB_STATE;

  function automatic logic [63:0] wb_addr(
    input logic [NUM_TAG_BITS-1:0] tag,
    input logic [NUM_SET_BITS-1:0] set_index
  );
    return 64'({tag, set_index, 3'b000});
  endfunction

endpackage

// File: rtl/vic_wb_buffer_if.sv
// Eviction, lookup, memory bus and status
// signals of the victim writeback buffer.
interface vic_wb_buffer_if #(
  parameter int WB_DEPTH = 4
) ();

  import sys_defs::*;

  localparam int CW = $clog2(WB_DEPTH) + 1;

  logic                    fired_valid;
  CACHE_LINE_T             fired_victim;
  logic [NUM_SET_BITS-1:0] fired_set_index;

  logic                    lookup_valid;
  logic [NUM_TAG_BITS-1:0] lookup_tag;
  logic [NUM_SET_BITS-1:0] lookup_set_index;
  logic                    lookup_hit;
  logic [63:0]             lookup_data;

  logic                    mem_grant;
  BUS_COMMAND              proc2mem_command;
  logic [63:0]             proc2mem_addr;
  logic [63:0]             proc2mem_data;
  logic [3:0]              mem2proc_response;

  logic                    full;
  logic                    empty;
  logic [CW-1:0]           count;
  logic                    overflow;

  modport slave (
    input  fired_valid, fired_victim,
    input  fired_set_index,
    input  lookup_valid, lookup_tag,
    input  lookup_set_index,
    input  mem_grant, mem2proc_response,
    output lookup_hit, lookup_data,
    output proc2mem_command,
    output proc2mem_addr, proc2mem_data,
    output full, empty, count, overflow
  );

  modport master (
    output fired_valid, fired_victim,
    output fired_set_index,
    output lookup_valid, lookup_tag,
    output lookup_set_index,
    output mem_grant, mem2proc_response,
    input  lookup_hit, lookup_data,
    input  proc2mem_command,
    input  proc2mem_addr, proc2mem_data,
    input  full, empty, count, overflow
  );

endinterface

// File: rtl/wb_cam.sv
// Tag/set match over the buffer entries; the
// youngest matching entry wins.
module wb_cam
  import sys_defs::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                    en_i,
  input  logic                    excl_head_i,
  input  logic [PW-1:0]           head_i,
  input  logic [NUM_TAG_BITS-1:0] tag_i,
  input  logic [NUM_SET_BITS-1:0] set_i,
  input  logic                    valid_i [DEPTH],
  input  logic [NUM_TAG_BITS-1:0] tags_i  [DEPTH],
  input  logic [NUM_SET_BITS-1:0] sets_i  [DEPTH],
  output logic                    hit_o,
  output logic [PW-1:0]           idx_o
);

  logic [PW-1:0] pos;

  // Walk oldest to youngest so later hits override.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    pos   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head_i + PW'(k);
      if (en_i && valid_i[pos] &&
          tags_i[pos] == tag_i &&
          sets_i[pos] == set_i &&
          !(excl_head_i && k == 0)) begin
        hit_o = 1'b1;
        idx_o = pos;
      end
    end
  end

endmodule

// File: rtl/vic_wb_buffer.sv
// Victim writeback buffer: queues evicted lines,
// coalesces repeats and drains them as stores.
module vic_wb_buffer
  import sys_defs::*;
  import vic_wb_buffer_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  vic_wb_buffer_if.slave  bus
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  WB_STATE   state_q, state_d;
  WB_ENTRY_T entries_q [WB_DEPTH];
  WB_ENTRY_T entries_d [WB_DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          present, deq, fire;
  logic          push, drop, full_w;
  logic          co_hit, lk_hit;
  logic [PW-1:0] co_idx, lk_idx;

  logic                    ev [WB_DEPTH];
  logic [NUM_TAG_BITS-1:0] et [WB_DEPTH];
  logic [NUM_SET_BITS-1:0] es [WB_DEPTH];

  always_comb begin
    for (int i = 0; i < WB_DEPTH; i++) begin
      ev[i] = entries_q[i].valid;
      et[i] = entries_q[i].tag;
      es[i] = entries_q[i].set_index;
    end
  end

  assign full_w  = count_q == CW'(WB_DEPTH);
  assign present = (state_q == WB_REQ) &&
                   bus.mem_grant;
  assign deq     = present &&
                   (bus.mem2proc_response != 4'h0);
  assign fire    = bus.fired_valid &&
                   bus.fired_victim.valid;
  assign push    = fire && !co_hit &&
                   (!full_w || deq);
  assign drop    = fire && !co_hit &&
                   full_w && !deq;

  // The head on the bus must keep stable data.
  wb_cam #(.DEPTH(WB_DEPTH)) u_co_cam (
    .en_i        (fire),
    .excl_head_i (present),
    .head_i      (head_q),
    .tag_i       (bus.fired_victim.tag),
    .set_i       (bus.fired_set_index),
    .valid_i     (ev),
    .tags_i      (et),
    .sets_i      (es),
    .hit_o       (co_hit),
    .idx_o       (co_idx)
  );

  wb_cam #(.DEPTH(WB_DEPTH)) u_lk_cam (
    .en_i        (bus.lookup_valid),
    .excl_head_i (1'b0),
    .head_i      (head_q),
    .tag_i       (bus.lookup_tag),
    .set_i       (bus.lookup_set_index),
    .valid_i     (ev),
    .tags_i      (et),
    .sets_i      (es),
    .hit_o       (lk_hit),
    .idx_o       (lk_idx)
  );

  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = drop;
    if (co_hit) begin
      entries_d[co_idx].data =
        bus.fired_victim.data;
    end
    if (deq) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (push) begin
      entries_d[tail_q] = '{
        valid:     1'b1,
        tag:       bus.fired_victim.tag,
        set_index: bus.fired_set_index,
        data:      bus.fired_victim.data
      };
      tail_d = tail_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(deq);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_IDLE:
        if (count_q != '0) state_d = WB_REQ;
      WB_REQ:
        if (count_d == '0) state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= WB_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      entries_q  <= entries_d;
    end
  end

  assign bus.proc2mem_command =
    present ? BUS_STORE : BUS_NONE;
  assign bus.proc2mem_addr = present ?
    wb_addr(entries_q[head_q].tag,
            entries_q[head_q].set_index) : '0;
  assign bus.proc2mem_data = present ?
    entries_q[head_q].data : '0;

  assign bus.lookup_hit  = lk_hit;
  assign bus.lookup_data = lk_hit ?
    entries_q[lk_idx].data : '0;

  assign bus.full     = full_w;
  assign bus.empty    = count_q == '0;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/vic_wb_buffer.md
VIC_WB_BUFFER -- requirements
Module: vic_wb_buffer

Interface
REQ-001 The block SHALL have parameter WB_DEPTH, default 4: number of writeback entries (power of two, at least 2).
REQ-002 The block SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port fired_valid, input, 1: the victim cache is evicting a line this cycle.
REQ-005 The block SHALL have port fired_victim, input, CACHE_LINE_T: the evicted line (valid, tag, data).
REQ-006 The block SHALL have port fired_set_index, input, NUM_SET_BITS: set index of the evicted line.
REQ-007 The block SHALL have ports lookup_valid (input, 1), lookup_tag (input, NUM_TAG_BITS) and lookup_set_index (input, NUM_SET_BITS): miss-path probe.
REQ-008 The block SHALL have ports lookup_hit (output, 1) and lookup_data (output, 64): probe result.
REQ-009 The block SHALL have port mem_grant, input, 1: the memory arbiter grants the bus to this block this cycle.
REQ-010 The block SHALL have ports proc2mem_command (output, 2, BUS_NONE/BUS_STORE), proc2mem_addr (output, 64) and proc2mem_data (output, 64).
REQ-011 The block SHALL have port mem2proc_response, input, 4: a nonzero value means the store was accepted.
REQ-012 The block SHALL have ports full (output, 1), empty (output, 1), count (output, log2(WB_DEPTH)+1) and overflow (output, 1, one-cycle pulse).

Function
REQ-013 The block SHALL form the entry address as zero-extended {tag, set_index, 3'b000}.
REQ-014 The block SHALL enqueue at the tail when fired_valid=1 and fired_victim.valid=1; it SHALL ignore input when fired_victim.valid=0.
REQ-015 If the incoming tag and set match a valid entry that is not the head currently being presented, the block SHALL overwrite that entry's data in place (coalesce), with no new slot and no change to count.
REQ-016 When full, an enqueue SHALL be accepted only if a dequeue occurs in the same cycle; otherwise the line SHALL be dropped and overflow SHALL pulse for one cycle.
REQ-017 The FSM SHALL have two states. IDLE: count=0, command BUS_NONE. REQ: head is valid.
REQ-018 The FSM SHALL go from IDLE to REQ in the cycle after count becomes nonzero; enqueue into an empty buffer SHALL NOT bypass to memory in the same cycle.
REQ-019 In REQ, the block SHALL drive BUS_STORE with head addr/data only while mem_grant=1; otherwise it SHALL drive BUS_NONE, addr 0, data 0.
REQ-020 In REQ, mem_grant=1 with a nonzero response SHALL dequeue the head at the edge; the FSM SHALL then stay in REQ if count after update is greater than 0, else go to IDLE.
REQ-021 In REQ, mem_grant=1 with response 0 SHALL retain the head and retry the next cycle with identical addr/data.
REQ-022 Lookup SHALL be combinational over all valid entries, including the head. If several entries match, the youngest SHALL win. An entry dequeued this cycle SHALL still hit. A line enqueued this cycle SHALL hit from the next cycle. lookup_valid=0 SHALL force hit 0 and data 0.
REQ-023 Head and tail pointers SHALL wrap modulo WB_DEPTH, and count SHALL never exceed WB_DEPTH.
REQ-024 full SHALL equal (count==WB_DEPTH) and empty SHALL equal (count==0), both registered-state derived.

Reset
REQ-025 On reset, the block SHALL invalidate all entries, set head=tail=count=0, set FSM to IDLE, and set outputs: command BUS_NONE, addr 0, data 0, lookup_hit 0, lookup_data 0, overflow 0, full 0, empty 1.
REQ-026 On reset during an in-flight store, the block SHALL abandon the store with no retry after reset deasserts.

Structure
REQ-027 The shared package SHALL hold WB_ENTRY_T (valid, tag, set_index, data) and the WB_STATE enum; CACHE_LINE_T, NUM_SET_BITS, NUM_TAG_BITS and the BUS_* commands SHALL come from sys_defs.
REQ-028 The match/priority logic SHALL be a sub-module wb_cam, shared by the lookup path and the coalesce path.

Verification (NUM_SET_BITS=5)
REQ-029 Scenario: reset asserted mid-REQ -> next cycle BUS_NONE, empty=1, count=0, no store after release.
REQ-030 Scenario: enqueue tag 10, set 15, data 5, grant=1, response=3 -> one cycle later BUS_STORE addr 0xA78 data 5; empty=1 after that edge.
REQ-031 Scenario: fill 4 entries, grant=0, fifth fired line -> overflow pulse, count stays 4; repeat with grant=1 and response=1 in the same cycle -> accepted, count 4, no overflow.
REQ-032 Scenario: grant=1 with response 0 for 3 cycles, then 2 -> same addr/data held for all 4 cycles, dequeued after the 4th.
REQ-033 Scenario: two enqueues of tag 4 set 13 (data 2, then 7) while not head -> count 1, lookup hit returns 7.
REQ-034 Scenario: lookup tag 6 set 9 in the cycle of its enqueue -> hit 0; next cycle -> hit 1 with its data.
